// File: rtl/req_priority_arbiter_if.sv
// Request/grant bundle between the requesters and the priority arbiter.
// The arbiter uses the slave modport and the requester side uses the master modport.
interface req_priority_arbiter_if #(
    parameter int N_REQ = 12
);
    logic [N_REQ-1:0] i_req;
    logic             i_done;
    logic             i_rr_mode;
    logic [N_REQ-1:0] o_grant;
    logic [3:0]       o_grant_id;
    logic             o_busy;
    logic             o_timeout;

    modport master (
        output i_req, i_done, i_rr_mode,
        input  o_grant, o_grant_id, o_busy, o_timeout
    );

    modport slave (
        input  i_req, i_done, i_rr_mode,
        output o_grant, o_grant_id, o_busy, o_timeout
    );
endinterface

// File: rtl/req_priority_arbiter.sv
// Shares one resource among 12 requesters with a registered one-hot grant, in fixed-priority or round-robin mode.
// A grant ends on done, on owner withdrawal or on a hold timeout, and is always followed by at least one idle cycle.
module req_priority_arbiter #(
    parameter int N_REQ    = 12,
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    req_priority_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_owner;
    logic [3:0]       r_last_idx;
    logic [N_REQ-1:0] r_grant;
    logic [3:0]       r_grant_id;
    logic             r_busy;
    logic             r_timeout;

    logic [3:0]       w_fixed_idx;
    logic [3:0]       w_rr_idx;
    logic [3:0]       w_win_idx;
    logic             w_owner_req;
    logic             w_release;

    // NOTE: every temporary gets a default before the loops, so no path through the block can infer a latch.
    always_comb begin : fixed_pick
        w_fixed_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (bus.i_req[k]) w_fixed_idx = 4'(k);
        end
    end

    // The distance below last_idx (wrapping, with last_idx itself at distance N_REQ) sets the round-robin rank.
    always_comb begin : rr_pick
        logic [3:0] w_dist;
        logic [3:0] w_best;
        w_rr_idx = '0;
        w_dist   = '0;
        w_best   = 4'd15;
        for (int k = 0; k < N_REQ; k++) begin
            w_dist = (r_last_idx > 4'(k)) ? (r_last_idx - 4'(k))
                                          : (r_last_idx + 4'(N_REQ - k));
            if (bus.i_req[k] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_rr_idx = 4'(k);
            end
        end
    end

    assign w_win_idx   = bus.i_rr_mode ? w_rr_idx : w_fixed_idx;
    assign w_owner_req = bus.i_req[r_owner];
    assign w_release   = bus.i_done || !w_owner_req || (r_cnt == HOLD_LAST);

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_owner    <= '0;
            r_last_idx <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.i_req) begin
                        r_state    <= S_GRANT;
                        r_owner    <= w_win_idx;
                        r_grant    <= N_REQ'(1) << w_win_idx;
                        r_grant_id <= w_win_idx + 4'd1;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state    <= S_IDLE;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                        r_busy     <= 1'b0;
                        r_last_idx <= r_owner;
                        r_timeout  <= !bus.i_done && w_owner_req;
                    end else begin
                        // Release always fires at HOLD_LAST, so the counter never has to wrap.
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_grant    = r_grant;
    assign bus.o_grant_id = r_grant_id;
    assign bus.o_busy     = r_busy;
    assign bus.o_timeout  = r_timeout;
endmodule
